block_check_sched: RTL and testbench
====================================

Name: block_check_sched

Overview:
- Round-robin scheduler that shares one BlockChecker-style begin/end checker between N character-stream requesters.
- Grants the checker to one requester for a whole message, then sequences it: clear, stream characters, append a terminating space, sample the result.
- Returns a per-requester pass/fail verdict.
- Sits between the text sources and the single shared checker instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_LEN, 64, maximum characters accepted per message before forced abort
LEN_W, 7, counter width; must hold MAX_LEN

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  N_REQ  requester i has a character on req_data[i]
req_data  in  8*N_REQ  ASCII character, slice i = [8i+7:8i]
req_last  in  N_REQ  character on requester i is the final one of its message
req_ready  out  N_REQ  one-hot; character of granted requester consumed this cycle when valid
chk_clr  out  1  one-cycle clear pulse to shared checker
chk_en  out  1  checker consumes chk_in on this edge
chk_in  out  8  character to checker
chk_result  in  1  checker verdict (1 = begin/end balanced) for all consumed characters
done  out  N_REQ  one-hot, one-cycle pulse: verdict for requester i available
done_ok  out  1  valid with done: checker verdict
done_err  out  1  valid with done: message aborted at MAX_LEN
busy  out  1  a message is in progress (state != IDLE)

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, grant pointer last=N_REQ-1 (requester 0 wins first).
  - Outputs: req_ready=0, chk_clr=0, chk_en=0, chk_in=8'h20, done=0, done_ok=0, done_err=0, busy=0, length counter=0.
  - Reset mid-message discards the message with no done pulse. The checker is re-cleared on the next grant.
- States: IDLE, CLEAR, STREAM, FLUSH, SAMPLE.
- IDLE:
  - If any req_valid, grant g = first requester with req_valid set, searching from (last+1) mod N_REQ upward with wrap. Go to CLEAR.
  - Else stay. Outputs idle values (chk_in=8'h20, chk_en=0).
- CLEAR:
  - chk_clr=1, chk_en=0, req_ready=0, length=0. Next state STREAM.
- STREAM:
  - req_ready[g]=1, all other req_ready=0.
  - chk_en=req_valid[g], chk_in=req_data slice g (combinational pass-through).
  - Requester stall (req_valid[g]=0): chk_en=0, checker state held. No word splitting, no timeout.
  - On each accepted beat, length+1.
  - If the beat has req_last[g]=1: go to FLUSH, err=0.
  - Else if length+1 == MAX_LEN: go to FLUSH, err=1, and req_ready[g]=0 from the next cycle. Remaining characters stay with the requester.
- FLUSH:
  - chk_en=1, chk_in=8'h20 for exactly one cycle, terminating the final word. Next state SAMPLE.
- SAMPLE:
  - chk_result reflects every consumed character plus the flush space.
  - Register done[g]=1, done_ok=chk_result & ~err, done_err=err. These are visible for one cycle, the cycle after SAMPLE.
  - Update last=g and go to IDLE.
- done/done_ok/done_err:
  - Zero in every cycle except the single reporting cycle.
  - A new grant may be issued in that same IDLE cycle.
- Latency: req_valid seen in IDLE at cycle t gives CLEAR at t+1, first req_ready at t+2. A k-character message with no stalls gets done at t+k+4.
- Grant is only changed in IDLE. req_valid of non-granted requesters is ignored during a message, and they are not starved under round-robin.
- req_last without req_valid is ignored. A 1-character message is legal.
- N_REQ=1 degenerates to a sequencer with the grant always 0.

Test Plan:
- Req0 sends "begin end" (9 chars, last on 'd') -> chk_clr one cycle, 9 chk_en beats, then one 8'h20 beat; done=0001, done_ok=1, done_err=0 at cycle t+13.
- Req1 sends "BeGin" -> done=0010, done_ok=0. Req1 then sends "end" -> done_ok=0, and chk_clr is seen before the second message.
- Req0 and req2 valid in the same IDLE cycle after reset -> req0 served first, then req2. Afterwards req0 and req2 again -> req2 wins (pointer last=0 gives priority to 1,2,…).
- Req3 sends "begin end" with req_valid low 3 cycles between 'g' and 'i' -> chk_en=0 during the gap, done_ok=1.
- MAX_LEN=8, req0 streams 10 chars without last -> exactly 8 chars accepted, then flush; done_err=1, done_ok=0. Req0's remaining chars start a new message after a re-grant.
- reset=0 asserted mid-STREAM -> outputs return to reset values immediately and no done is pulsed. The next message still gets a correct verdict after a fresh chk_clr.

Source files
------------

// File: rtl/block_check_sched.sv
// Round-robin scheduler sharing one begin/end block checker between N_REQ character streams.
// Each grant runs clear -> stream -> flush space -> sample, then reports a one-cycle verdict.
module block_check_sched #(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 chk_clr,
    output logic                 chk_en,
    output logic [7:0]           chk_in,
    input  logic                 chk_result,
    output logic [N_REQ-1:0]     done,
    output logic                 done_ok,
    output logic                 done_err,
    output logic                 busy
);

    // state  | meaning
    // IDLE   | no message; arbitrate among valid requesters
    // CLEAR  | pulse chk_clr to the shared checker
    // STREAM | pass granted requester's characters to the checker
    // FLUSH  | feed one space to close the final word
    // SAMPLE | capture the checker verdict, update round-robin pointer
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, SAMPLE} state_t;

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state, state_nxt;
    logic [GW-1:0]      grant, last, pick;
    logic [LEN_W-1:0]   len, len_inc;
    logic               err;
    logic [N_REQ-1:0]   grant_oh;
    logic               cur_valid, cur_last, at_max;
    logic [7:0]         cur_data;

    assign grant_oh  = N_REQ'(1) << grant;
    assign cur_valid = req_valid[grant];
    assign cur_last  = req_last[grant];
    assign cur_data  = req_data[{grant, 3'b000} +: 8];
    assign len_inc   = len + LEN_W'(1);
    assign at_max    = (len_inc == LEN_W'(MAX_LEN));
    assign busy      = (state != IDLE);

    // First valid requester after the previous winner, wrapping around.
    always_comb begin
        logic [GW-1:0] ci;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            ci = GW'((int'(last) + k) % N_REQ);
            if (!found && req_valid[ci]) begin
                pick  = ci;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= GW'(N_REQ - 1);
            len      <= '0;
            err      <= 1'b0;
            done     <= '0;
            done_ok  <= 1'b0;
            done_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= '0;
            done_ok  <= 1'b0;
            done_err <= 1'b0;
            case (state)
                IDLE: if (|req_valid) grant <= pick;
                CLEAR: begin
                    len <= '0;
                    err <= 1'b0;
                end
                STREAM: if (cur_valid) begin
                    len <= len_inc;
                    if (!cur_last && at_max) err <= 1'b1;
                end
                SAMPLE: begin
                    done     <= grant_oh;
                    done_ok  <= chk_result & ~err;
                    done_err <= err;
                    last     <= grant;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        chk_clr   = 1'b0;
        chk_en    = 1'b0;
        chk_in    = 8'h20;
        case (state)
            IDLE:  if (|req_valid) state_nxt = CLEAR;
            CLEAR: begin
                chk_clr   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                req_ready[grant] = 1'b1;
                chk_en           = cur_valid;
                chk_in           = cur_data;
                if (cur_valid && (cur_last || at_max)) state_nxt = FLUSH;
            end
            FLUSH: begin
                chk_en    = 1'b1;
                state_nxt = SAMPLE;
            end
            SAMPLE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_check_sched.sv
// Bench for block_check_sched: behavioural begin/end checker plus message-level reference model.
module tb_block_check_sched;
    localparam int N  = 4;
    localparam int ML = 12;
    localparam int LW = 4;
    localparam int DW = 8 * N;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [DW-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready, done;
    logic          chk_clr, chk_en, chk_result, done_ok, done_err, busy;
    logic [7:0]    chk_in;

    int checks = 0;
    int failures = 0;
    int model_last = N - 1;
    logic [7:0] m_q[$];
    int gap_q[$];

    block_check_sched #(.N_REQ(N), .MAX_LEN(ML), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .chk_clr(chk_clr), .chk_en(chk_en),
        .chk_in(chk_in), .chk_result(chk_result), .done(done), .done_ok(done_ok),
        .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lc(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction

    // Shared checker: case-insensitive words, begin/end must nest and balance.
    string cw = "";
    int    cdepth = 0;
    bit    cbad = 1'b0;
    always @(posedge clk) begin : checker_model
        string w;
        int    d;
        bit    b;
        w = cw; d = cdepth; b = cbad;
        if (chk_clr) begin
            w = ""; d = 0; b = 1'b0;
        end else if (chk_en) begin
            if (chk_in == 8'h20) begin
                if (w == "begin") d++;
                else if (w == "end") begin
                    if (d == 0) b = 1'b1;
                    else d--;
                end
                w = "";
            end else w = $sformatf("%s%c", w, lc(chk_in));
        end
        cw <= w; cdepth <= d; cbad <= b;
    end
    assign chk_result = !cbad && (cdepth == 0);

    // Verdict for the first a characters plus terminating space: +1/-1 token prefix sums.
    function automatic bit exp_verdict(input int a);
        string w;
        int toks[$];
        int s;
        logic [7:0] c;
        w = "";
        for (int i = 0; i <= a; i++) begin
            c = (i == a) ? 8'h20 : m_q[i];
            if (c == 8'h20) begin
                if (w == "begin") toks.push_back(1);
                else if (w == "end") toks.push_back(-1);
                w = "";
            end else w = $sformatf("%s%c", w, lc(c));
        end
        s = 0;
        foreach (toks[i]) begin
            s += toks[i];
            if (s < 0) return 1'b0;
        end
        return s == 0;
    endfunction

    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] d, input int g, input logic [7:0] c);
        logic [DW-1:0] m;
        m = DW'(8'hFF) << (8 * g);
        return (d & ~m) | (DW'(c) << (8 * g));
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (model_last + k) % N;
            if (((mask >> c) & N'(1)) != '0) return c;
        end
        return -1;
    endfunction

    task automatic set_msg(input string s);
        m_q.delete();
        gap_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            m_q.push_back(s[i]);
            gap_q.push_back(0);
        end
        gap_q.push_back(0);
    endtask

    // Runs one whole message on the requester the round-robin model predicts for mask.
    task automatic run_msg(input logic [N-1:0] mask, input string name);
        int g, a, s, n_done, idx, gc, clr_cnt, clr_n, rdy_n;
        logic [N-1:0] oh, rdy_v, v, l, done_v;
        logic [DW-1:0] d;
        logic [7:0] beats[$];
        logic [7:0] exp_b[$];
        bit err, ok, rdy_bad, done_bad, busy_ok, dok, derr, beats_ok;
        g = rr_pick(mask);
        a = (m_q.size() > ML) ? ML : m_q.size();
        err = (m_q.size() > ML);
        s = a;
        for (int i = 0; i < a; i++) s += gap_q[i];
        n_done = s + 4;
        oh = N'(1) << g;
        ok = exp_verdict(a) && !err;
        for (int i = 0; i < a; i++) exp_b.push_back(m_q[i]);
        exp_b.push_back(8'h20);
        idx = 0; gc = gap_q[0]; clr_cnt = 0; clr_n = -1; rdy_n = -1; rdy_v = '0;
        rdy_bad = 0; done_bad = 0; busy_ok = 1; done_v = '0; dok = 0; derr = 0;
        for (int n = 0; n <= n_done + 1; n++) begin
            @(negedge clk);
            v = '0; l = N'($urandom); d = DW'($urandom);
            if (n < n_done) v = mask & ~oh;
            if (n < n_done && idx < m_q.size() && !(n >= 2 && gc > 0)) begin
                v |= oh;
                d = put_byte(d, g, m_q[idx]);
                l = (idx == m_q.size() - 1) ? (l | oh) : (l & ~oh);
            end
            req_valid = v; req_last = l; req_data = d;
            #1;
            if (chk_clr) begin clr_cnt++; clr_n = n; end
            if ((req_ready & ~oh) != '0) rdy_bad = 1;
            if (req_ready != '0 && rdy_n < 0) begin rdy_n = n; rdy_v = req_ready; end
            if (chk_en) beats.push_back(chk_in);
            if (n == n_done) begin done_v = done; dok = done_ok; derr = done_err; end
            else if (done != '0 || done_ok || done_err) done_bad = 1;
            if ((n == 1 && !busy) || (n == n_done + 1 && busy)) busy_ok = 0;
            if (n >= 2 && n < n_done && idx < m_q.size()) begin
                if (gc > 0) gc--;
                else if ((req_ready & oh) != '0) begin
                    idx++;
                    gc = (idx < gap_q.size()) ? gap_q[idx] : 0;
                end
            end
        end
        req_valid = '0; req_last = '0;
        beats_ok = (beats.size() == exp_b.size());
        if (beats_ok) foreach (exp_b[i]) if (beats[i] !== exp_b[i]) beats_ok = 0;

        checks++;
        if (rdy_n != 2 || rdy_v !== oh) begin
            failures++;
            $display("FAIL %s grant: ready %b at cycle %0d, expected %b at cycle 2", name, rdy_v, rdy_n, oh);
        end
        checks++;
        if (clr_cnt != 1 || clr_n != 1) begin
            failures++;
            $display("FAIL %s chk_clr: %0d pulses last at cycle %0d, expected 1 pulse at cycle 1", name, clr_cnt, clr_n);
        end
        checks++;
        if (rdy_bad) begin
            failures++;
            $display("FAIL %s ready_onehot: ready raised on a lane other than %b", name, oh);
        end
        checks++;
        if (!beats_ok) begin
            failures++;
            $display("FAIL %s chk_beats: got %0d beats, expected %0d (message plus space)", name, beats.size(), exp_b.size());
        end
        checks++;
        if (done_v !== oh) begin
            failures++;
            $display("FAIL %s done: got %b at cycle %0d, expected %b", name, done_v, n_done, oh);
        end
        checks++;
        if (dok !== ok) begin
            failures++;
            $display("FAIL %s done_ok: got %b expected %b", name, dok, ok);
        end
        checks++;
        if (derr !== err) begin
            failures++;
            $display("FAIL %s done_err: got %b expected %b", name, derr, err);
        end
        checks++;
        if (done_bad || !busy_ok) begin
            failures++;
            $display("FAIL %s pulse_window: spurious done %b, busy ok %b (expected 0, 1)", name, done_bad, busy_ok);
        end
        model_last = g;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'b1011; req_last = '1; req_data = DW'($urandom);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, chk_clr, chk_en, busy} !== '0 || chk_in !== 8'h20) begin
            failures++;
            $display("FAIL reset_outputs: ready %b clr %b en %b busy %b in %h, expected 0 0 0 0 20", req_ready, chk_clr, chk_en, busy, chk_in);
        end
        checks++;
        if ({done, done_ok, done_err} !== '0) begin
            failures++;
            $display("FAIL reset_done: done %b ok %b err %b, expected all 0", done, done_ok, done_err);
        end
        @(negedge clk);
        req_valid = '0; req_last = '0;
        reset = 1'b1;
        model_last = N - 1;
    endtask

    task automatic test_basic();
        set_msg("begin end");
        run_msg(4'b0001, "basic_req0");
    endtask

    task automatic test_clear();
        set_msg("BeGin");
        run_msg(4'b0010, "req1_begin");
        set_msg("end");
        run_msg(4'b0010, "req1_end");
    endtask

    task automatic test_round_robin();
        set_msg("end begin");
        run_msg(4'b0101, "rr_first");
        set_msg("begin end");
        run_msg(4'b0101, "rr_second");
        set_msg("x");
        run_msg(4'b0101, "rr_third");
    endtask

    task automatic test_stall();
        set_msg("begin end");
        gap_q[3] = 3;
        run_msg(4'b1000, "stall_req3");
    endtask

    task automatic test_abort();
        set_msg("begin end xyzw");
        run_msg(4'b0001, "abort");
        set_msg("zw");
        run_msg(4'b0001, "abort_rest");
        set_msg("begin    end");
        run_msg(4'b0001, "exact_max");
    endtask

    // Second requester is granted in the very cycle the first verdict is reported.
    task automatic test_back_to_back();
        int g1, g2;
        logic [N-1:0] oh1, oh2, v;
        logic [DW-1:0] d;
        g1 = rr_pick(4'b0011);
        g2 = (g1 == 0) ? 1 : 0;
        oh1 = N'(1) << g1;
        oh2 = N'(1) << g2;
        for (int n = 0; n <= 11; n++) begin
            @(negedge clk);
            v = '0;
            if (n <= 2) v |= oh1;
            if (n <= 7) v |= oh2;
            d = put_byte(put_byte(DW'($urandom), g1, "x"), g2, "x");
            req_valid = v; req_last = v; req_data = d;
            #1;
            if (n == 5) begin
                checks++;
                if (done !== oh1 || done_ok !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_done1: done %b ok %b, expected %b 1", done, done_ok, oh1);
                end
            end
            if (n == 6) begin
                checks++;
                if (chk_clr !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_clear: chk_clr %b, expected 1", chk_clr);
                end
            end
            if (n == 7) begin
                checks++;
                if (req_ready !== oh2) begin
                    failures++;
                    $display("FAIL b2b_grant2: ready %b, expected %b", req_ready, oh2);
                end
            end
            if (n == 10) begin
                checks++;
                if (done !== oh2 || done_ok !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_done2: done %b ok %b, expected %b 1", done, done_ok, oh2);
                end
            end
        end
        req_valid = '0; req_last = '0;
        model_last = g2;
    endtask

    task automatic test_reset_mid();
        string s;
        bit bad;
        s = "begin";
        bad = 0;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            req_valid = 4'b0100; req_last = '0;
            req_data = put_byte(DW'($urandom), 2, s[(n < 2) ? 0 : n - 2]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, chk_clr, chk_en, busy, done, done_ok, done_err} !== '0 || chk_in !== 8'h20) begin
            failures++;
            $display("FAIL reset_mid_outputs: ready %b clr %b en %b busy %b done %b in %h, expected zeros and 20", req_ready, chk_clr, chk_en, busy, done, chk_in);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            if (done != '0 || busy) bad = 1;
        end
        @(negedge clk);
        reset = 1'b1; req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done != '0 || done_ok || busy) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_quiet: done or busy seen after mid-message reset, expected none");
        end
        model_last = N - 1;
        set_msg("begin end");
        run_msg(4'b0100, "post_reset");
    endtask

    function automatic string pick_word(input int k);
        case (k)
            0: return "begin";
            1: return "end";
            2: return "BEGIN";
            3: return "End";
            4: return "x";
            default: return "ab";
        endcase
    endfunction

    task automatic test_random();
        string s;
        logic [N-1:0] mask;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, 15));
            s = "";
            for (int w = 0; w < $urandom_range(1, 4); w++) begin
                if (w > 0) s = {s, " "};
                s = {s, pick_word($urandom_range(0, 5))};
            end
            set_msg(s);
            foreach (gap_q[i]) gap_q[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_msg(mask, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_round_robin();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
